// File: rtl/redmule_tile_ctrl_pkg.sv
// Shared types and constants for the RedMulE tile bring-up/power sequencer.
// Optional wake watchdog is enabled by defining REDMULE_TILE_CTRL_WDOG_EN.
package redmule_tile_ctrl_pkg;

    localparam int unsigned N_EVT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENABLE = 3'd1,
        ST_BOOT   = 3'd2,
        ST_RUN    = 3'd3,
        ST_SLEEP  = 3'd4,
        ST_WAKE   = 3'd5,
        ST_DRAIN  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        FL_IDLE = 2'd0,
        FL_WAIT = 2'd1,
        FL_ACK  = 2'd2
    } flush_state_e;

    localparam state_e       ST_RESET = ST_IDLE;
    localparam flush_state_e FL_RESET = FL_IDLE;
    localparam logic         RST_OUT  = 1'b0;

    // Width able to hold (max(a,b) - 1), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/redmule_tile_ctrl_if.sv
// Control/status bundle between the cluster registers, the tile pins and the sequencer.
interface redmule_tile_ctrl_if
    import redmule_tile_ctrl_pkg::*;
#(
    parameter int unsigned N_EVT = N_EVT_DEF
);
    logic             start_i;
    logic             stop_i;
    logic [N_EVT-1:0] evt_i;
    logic [N_EVT-1:0] evt_mask_i;
    logic             core_sleep_i;
    logic             wu_wfe_o;
    logic             tile_enable_o;
    logic             fetch_enable_o;
    logic             fencei_flush_req_i;
    logic             fencei_flush_ack_o;
    logic [N_EVT-1:0] evt_pending_o;
    logic [2:0]       state_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    modport slave (
        input  start_i, stop_i, evt_i, evt_mask_i, core_sleep_i, fencei_flush_req_i,
        output wu_wfe_o, tile_enable_o, fetch_enable_o, fencei_flush_ack_o,
               evt_pending_o, state_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, stop_i, evt_i, evt_mask_i, core_sleep_i, fencei_flush_req_i,
        input  wu_wfe_o, tile_enable_o, fetch_enable_o, fencei_flush_ack_o,
               evt_pending_o, state_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/redmule_tile_ctrl_flush.sv
// fence.i flush req/ack responder: ack rises FLUSH_LAT cycles after req rises,
// drops the cycle after req falls; held in reset while the sequencer is idle.
module redmule_tile_ctrl_flush
    import redmule_tile_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_LAT = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_active,
    input  logic i_req,
    output logic o_ack
);

    localparam int unsigned    LAT_W    = (FLUSH_LAT > 2) ? $clog2(FLUSH_LAT - 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = (FLUSH_LAT >= 2) ? LAT_W'(FLUSH_LAT - 2) : '0;

    flush_state_e     r_state;
    flush_state_e     w_state_nxt;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_nxt;
    logic             r_req_q;
    logic             w_req_rise;

    assign w_req_rise = i_req & ~r_req_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= FL_RESET;
            r_cnt   <= '0;
            r_req_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req_q <= i_req;
        end
    end

    // The rise cycle itself counts as the first latency cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            FL_IDLE: begin
                if (w_req_rise) begin
                    if (FLUSH_LAT == 1) begin
                        w_state_nxt = FL_ACK;
                    end else begin
                        w_state_nxt = FL_WAIT;
                        w_cnt_nxt   = LAT_LOAD;
                    end
                end
            end
            FL_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = FL_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - LAT_W'(1);
                end
            end
            FL_ACK: begin
                if (!i_req) begin
                    w_state_nxt = FL_IDLE;
                end
            end
            default: w_state_nxt = FL_IDLE;
        endcase
        if (!i_active) begin
            w_state_nxt = FL_IDLE;
        end
    end

    assign o_ack = (r_state == FL_ACK) & i_active;

endmodule

// File: rtl/redmule_tile_ctrl.sv
// Bring-up, sleep/wake and shutdown sequencer for one RedMulE tile.
// Define REDMULE_TILE_CTRL_WDOG_EN to add the wake watchdog (err_o, forced drain).
module redmule_tile_ctrl
    import redmule_tile_ctrl_pkg::*;
#(
    parameter int unsigned N_EVT       = N_EVT_DEF,
    parameter int unsigned ENABLE_DLY  = 4,
    parameter int unsigned FLUSH_LAT   = 2,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    redmule_tile_ctrl_if.slave  bus_if
);

    localparam int unsigned      CNT_W       = cnt_width(ENABLE_DLY, WDOG_CYCLES);
    localparam logic [CNT_W-1:0] ENABLE_LOAD = CNT_W'(ENABLE_DLY - 1);
`ifdef REDMULE_TILE_CTRL_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LOAD   = CNT_W'(WDOG_CYCLES - 1);
`endif

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [N_EVT-1:0] r_pend;
    logic [N_EVT-1:0] w_pend_nxt;
    logic [N_EVT-1:0] w_pend_clr;
    logic             r_tile_en;
    logic             r_fetch_en;
    logic             r_wu_wfe;
    logic             r_done;
    logic             w_wake_req;
    logic             w_active;
    logic             w_flush_ack;
`ifdef REDMULE_TILE_CTRL_WDOG_EN
    logic             w_err_set;
    logic             r_err;
`endif

    assign w_wake_req = |(r_pend & bus_if.evt_mask_i);
    assign w_active   = (r_state != ST_IDLE);

    // Pin drivers are registered from the next state so they change with the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_RESET;
            r_cnt      <= '0;
            r_pend     <= '0;
            r_tile_en  <= RST_OUT;
            r_fetch_en <= RST_OUT;
            r_wu_wfe   <= RST_OUT;
            r_done     <= RST_OUT;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend     <= w_pend_nxt;
            r_tile_en  <= (w_state_nxt != ST_IDLE);
            r_fetch_en <= (w_state_nxt == ST_BOOT)  || (w_state_nxt == ST_RUN) ||
                          (w_state_nxt == ST_SLEEP) || (w_state_nxt == ST_WAKE);
            r_wu_wfe   <= (w_state_nxt == ST_WAKE);
            r_done     <= (r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? (r_cnt - CNT_W'(1)) : '0;
        w_pend_clr  = '0;
`ifdef REDMULE_TILE_CTRL_WDOG_EN
        w_err_set   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus_if.start_i) begin
                    w_state_nxt = ST_ENABLE;
                    w_cnt_nxt   = ENABLE_LOAD;
                end
            end
            ST_ENABLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_BOOT;
                end
            end
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus_if.stop_i) begin
                    w_state_nxt = ST_DRAIN;
                end else if (bus_if.core_sleep_i) begin
                    w_state_nxt = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (bus_if.stop_i) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_wake_req) begin
                    w_state_nxt = ST_WAKE;
`ifdef REDMULE_TILE_CTRL_WDOG_EN
                    w_cnt_nxt   = WDOG_LOAD;
`endif
                end
            end
            ST_WAKE: begin
                if (!bus_if.core_sleep_i) begin
                    w_state_nxt = ST_RUN;
                    w_pend_clr  = bus_if.evt_mask_i;
`ifdef REDMULE_TILE_CTRL_WDOG_EN
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_DRAIN;
                    w_err_set   = 1'b1;
`endif
                end
            end
            ST_DRAIN: begin
                if (bus_if.core_sleep_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A new event wins over the wake-time clear of the same bit.
        w_pend_nxt = (r_pend & ~w_pend_clr) | (w_active ? bus_if.evt_i : '0);
        if (w_state_nxt == ST_IDLE) begin
            w_pend_nxt = '0;
        end
    end

`ifdef REDMULE_TILE_CTRL_WDOG_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= RST_OUT;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end
    assign bus_if.err_o = r_err;
`else
    assign bus_if.err_o = 1'b0;
`endif

    redmule_tile_ctrl_flush #(
        .FLUSH_LAT (FLUSH_LAT)
    ) u_flush (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_active (w_active),
        .i_req    (bus_if.fencei_flush_req_i),
        .o_ack    (w_flush_ack)
    );

    assign bus_if.wu_wfe_o           = r_wu_wfe;
    assign bus_if.tile_enable_o      = r_tile_en;
    assign bus_if.fetch_enable_o     = r_fetch_en;
    assign bus_if.fencei_flush_ack_o = w_flush_ack;
    assign bus_if.evt_pending_o      = r_pend;
    assign bus_if.state_o            = r_state;
    assign bus_if.busy_o             = w_active;
    assign bus_if.done_o             = r_done;

endmodule

// File: tb/tb_redmule_tile_ctrl.sv
// Scoreboard bench for redmule_tile_ctrl: each row holds one cycle of stimulus and
// the outputs expected after the next clock edge.
module tb_redmule_tile_ctrl;

    localparam int unsigned N_EVT       = 8;
    localparam int unsigned ENABLE_DLY  = 4;
    localparam int unsigned FLUSH_LAT   = 2;
    localparam int unsigned WDOG_CYCLES = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    redmule_tile_ctrl_if #(.N_EVT(N_EVT)) bus_if ();

    redmule_tile_ctrl #(
        .N_EVT       (N_EVT),
        .ENABLE_DLY  (ENABLE_DLY),
        .FLUSH_LAT   (FLUSH_LAT),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus_if (bus_if)
    );

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       sleep;
        logic       req;
        logic [7:0] evt;
        logic [7:0] mask;
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic       busy;
        logic       te;
        logic       fe;
        logic       wu;
        logic       ack;
        logic       done;
        logic       err;
        logic [7:0] pend;
    } snap_t;

    typedef struct packed {
        stim_t s;
        snap_t e;
    } row_t;

    row_t q_sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic stim_t stm(logic start, logic stop, logic sleep, logic req,
                                  logic [7:0] evt, logic [7:0] mask);
        stim_t s;
        s.start = start; s.stop = stop; s.sleep = sleep; s.req = req;
        s.evt = evt; s.mask = mask;
        return s;
    endfunction

    function automatic snap_t ex(logic [2:0] st, logic te, logic fe, logic wu, logic ack,
                                 logic done, logic err, logic [7:0] pend);
        snap_t e;
        e.st = st; e.busy = (st != 3'd0); e.te = te; e.fe = fe; e.wu = wu;
        e.ack = ack; e.done = done; e.err = err; e.pend = pend;
        return e;
    endfunction

    function automatic snap_t observe();
        snap_t o;
        o.st   = bus_if.state_o;
        o.busy = bus_if.busy_o;
        o.te   = bus_if.tile_enable_o;
        o.fe   = bus_if.fetch_enable_o;
        o.wu   = bus_if.wu_wfe_o;
        o.ack  = bus_if.fencei_flush_ack_o;
        o.done = bus_if.done_o;
        o.err  = bus_if.err_o;
        o.pend = bus_if.evt_pending_o;
        return o;
    endfunction

    task automatic push(input stim_t s, input snap_t e);
        row_t r;
        r.s = s;
        r.e = e;
        q_sb.push_back(r);
    endtask

    task automatic drive(input stim_t s);
        bus_if.start_i            = s.start;
        bus_if.stop_i             = s.stop;
        bus_if.core_sleep_i       = s.sleep;
        bus_if.fencei_flush_req_i = s.req;
        bus_if.evt_i              = s.evt;
        bus_if.evt_mask_i         = s.mask;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // IDLE -> ENABLE (4 cycles) -> BOOT -> RUN
    task automatic push_bringup();
        push(stm(1, 0, 0, 0, 8'h00, 8'h00), ex(3'd1, 1, 0, 0, 0, 0, 0, 8'h00));
        for (int i = 0; i < 3; i++)
            push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd1, 1, 0, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd2, 1, 1, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd3, 1, 1, 0, 0, 0, 0, 8'h00));
    endtask

    task automatic test_reset();
        snap_t act;
        drive(stm(0, 0, 0, 0, 8'h00, 8'h00));
        rst_i = 1'b1;
        repeat (3) tick();
        act = observe();
        checks++;
        if (act !== snap_t'(0)) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", act, snap_t'(0));
        end
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++)
            push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd0, 0, 0, 0, 0, 0, 0, 8'h00));
        for (int idx = 0; q_sb.size() > 0; idx++) begin
            row_t r = q_sb.pop_front();
            drive(r.s);
            tick();
            act = observe();
            checks++;
            if (act !== r.e) begin
                errors++;
                $display("FAIL reset_idle row %0d: got %h expected %h", idx, act, r.e);
            end
        end
    endtask

    task automatic test_bringup();
        snap_t act;
        push_bringup();
        push(stm(1, 0, 0, 0, 8'h00, 8'h00), ex(3'd3, 1, 1, 0, 0, 0, 0, 8'h00));
        for (int idx = 0; q_sb.size() > 0; idx++) begin
            row_t r = q_sb.pop_front();
            drive(r.s);
            tick();
            act = observe();
            checks++;
            if (act !== r.e) begin
                errors++;
                $display("FAIL bringup row %0d: got %h expected %h", idx, act, r.e);
            end
        end
    endtask

    task automatic test_flush();
        snap_t act;
        logic req_v [9] = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
        logic ack_v [9] = '{0, 1, 1, 1, 1, 0, 0, 1, 0};
        for (int i = 0; i < 9; i++)
            push(stm(0, 0, 0, req_v[i], 8'h00, 8'h00),
                 ex(3'd3, 1, 1, 0, ack_v[i], 0, 0, 8'h00));
        for (int idx = 0; q_sb.size() > 0; idx++) begin
            row_t r = q_sb.pop_front();
            drive(r.s);
            tick();
            act = observe();
            checks++;
            if (act !== r.e) begin
                errors++;
                $display("FAIL flush row %0d: got %h expected %h", idx, act, r.e);
            end
        end
    endtask

    task automatic test_sleep_wake();
        snap_t act;
        push(stm(0, 0, 1, 0, 8'h00, 8'h00), ex(3'd4, 1, 1, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 1, 0, 8'h04, 8'h04), ex(3'd4, 1, 1, 0, 0, 0, 0, 8'h04));
        push(stm(0, 0, 1, 0, 8'h00, 8'h04), ex(3'd5, 1, 1, 1, 0, 0, 0, 8'h04));
        push(stm(0, 0, 1, 0, 8'h00, 8'h04), ex(3'd5, 1, 1, 1, 0, 0, 0, 8'h04));
        push(stm(0, 0, 0, 0, 8'h00, 8'h04), ex(3'd3, 1, 1, 0, 0, 0, 0, 8'h00));
        for (int idx = 0; q_sb.size() > 0; idx++) begin
            row_t r = q_sb.pop_front();
            drive(r.s);
            tick();
            act = observe();
            checks++;
            if (act !== r.e) begin
                errors++;
                $display("FAIL sleep_wake row %0d: got %h expected %h", idx, act, r.e);
            end
        end
    endtask

    task automatic test_masked();
        snap_t act;
        push(stm(0, 0, 1, 0, 8'h00, 8'h00), ex(3'd4, 1, 1, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 1, 0, 8'h03, 8'h00), ex(3'd4, 1, 1, 0, 0, 0, 0, 8'h03));
        push(stm(0, 0, 1, 0, 8'h00, 8'h00), ex(3'd4, 1, 1, 0, 0, 0, 0, 8'h03));
        push(stm(0, 0, 1, 0, 8'h00, 8'h01), ex(3'd5, 1, 1, 1, 0, 0, 0, 8'h03));
        // fresh event on bit 0 during the clearing edge survives; bit 1 was never enabled
        push(stm(0, 0, 0, 0, 8'h01, 8'h01), ex(3'd3, 1, 1, 0, 0, 0, 0, 8'h03));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd3, 1, 1, 0, 0, 0, 0, 8'h03));
        for (int idx = 0; q_sb.size() > 0; idx++) begin
            row_t r = q_sb.pop_front();
            drive(r.s);
            tick();
            act = observe();
            checks++;
            if (act !== r.e) begin
                errors++;
                $display("FAIL masked row %0d: got %h expected %h", idx, act, r.e);
            end
        end
    endtask

    task automatic test_shutdown();
        snap_t act;
        push(stm(0, 1, 1, 0, 8'h00, 8'h00), ex(3'd6, 1, 0, 0, 0, 0, 0, 8'h03));
        push(stm(0, 0, 1, 0, 8'h00, 8'h00), ex(3'd0, 0, 0, 0, 0, 1, 0, 8'h00));
        push(stm(0, 0, 1, 0, 8'h00, 8'h00), ex(3'd0, 0, 0, 0, 0, 0, 0, 8'h00));
        push(stm(0, 1, 0, 0, 8'h00, 8'h00), ex(3'd0, 0, 0, 0, 0, 0, 0, 8'h00));
        for (int i = 0; i < 3; i++)
            push(stm(0, 0, 0, 1, 8'h00, 8'h00), ex(3'd0, 0, 0, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd0, 0, 0, 0, 0, 0, 0, 8'h00));
        for (int idx = 0; q_sb.size() > 0; idx++) begin
            row_t r = q_sb.pop_front();
            drive(r.s);
            tick();
            act = observe();
            checks++;
            if (act !== r.e) begin
                errors++;
                $display("FAIL shutdown row %0d: got %h expected %h", idx, act, r.e);
            end
        end
    endtask

    task automatic test_back_to_back();
        snap_t act;
        push(stm(1, 0, 0, 0, 8'h00, 8'h00), ex(3'd1, 1, 0, 0, 0, 0, 0, 8'h00));
        push(stm(0, 1, 0, 0, 8'h00, 8'h00), ex(3'd1, 1, 0, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd1, 1, 0, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd1, 1, 0, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd2, 1, 1, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd3, 1, 1, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 1, 0, 8'h00, 8'h00), ex(3'd4, 1, 1, 0, 0, 0, 0, 8'h00));
        push(stm(0, 1, 0, 0, 8'h00, 8'h00), ex(3'd6, 1, 0, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd6, 1, 0, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd6, 1, 0, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 1, 0, 8'h00, 8'h00), ex(3'd0, 0, 0, 0, 0, 1, 0, 8'h00));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd0, 0, 0, 0, 0, 0, 0, 8'h00));
        for (int idx = 0; q_sb.size() > 0; idx++) begin
            row_t r = q_sb.pop_front();
            drive(r.s);
            tick();
            act = observe();
            checks++;
            if (act !== r.e) begin
                errors++;
                $display("FAIL back_to_back row %0d: got %h expected %h", idx, act, r.e);
            end
        end
    endtask

    task automatic test_async_reset();
        snap_t act;
        push_bringup();
        push(stm(0, 0, 0, 0, 8'h10, 8'h00), ex(3'd3, 1, 1, 0, 0, 0, 0, 8'h10));
        for (int idx = 0; q_sb.size() > 0; idx++) begin
            row_t r = q_sb.pop_front();
            drive(r.s);
            tick();
            act = observe();
            checks++;
            if (act !== r.e) begin
                errors++;
                $display("FAIL async_setup row %0d: got %h expected %h", idx, act, r.e);
            end
        end
        drive(stm(0, 0, 0, 0, 8'h00, 8'h00));
        #2;
        rst_i = 1'b1;
        #1;
        act = observe();
        checks++;
        if (act !== snap_t'(0)) begin
            errors++;
            $display("FAIL async_reset_midcycle: got %h expected %h", act, snap_t'(0));
        end
        tick();
        rst_i = 1'b0;
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd0, 0, 0, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 0, 0, 8'h00, 8'h00), ex(3'd0, 0, 0, 0, 0, 0, 0, 8'h00));
        for (int idx = 0; q_sb.size() > 0; idx++) begin
            row_t r = q_sb.pop_front();
            drive(r.s);
            tick();
            act = observe();
            checks++;
            if (act !== r.e) begin
                errors++;
                $display("FAIL async_after row %0d: got %h expected %h", idx, act, r.e);
            end
        end
    endtask

    task automatic test_wake_hold();
        snap_t act;
        push_bringup();
        push(stm(0, 0, 1, 0, 8'h00, 8'h00), ex(3'd4, 1, 1, 0, 0, 0, 0, 8'h00));
        push(stm(0, 0, 1, 0, 8'h04, 8'h04), ex(3'd4, 1, 1, 0, 0, 0, 0, 8'h04));
`ifdef REDMULE_TILE_CTRL_WDOG_EN
        for (int i = 0; i < WDOG_CYCLES; i++)
            push(stm(0, 0, 1, 0, 8'h00, 8'h04), ex(3'd5, 1, 1, 1, 0, 0, 0, 8'h04));
        push(stm(0, 0, 1, 0, 8'h00, 8'h04), ex(3'd6, 1, 0, 0, 0, 0, 1, 8'h04));
        push(stm(0, 0, 1, 0, 8'h00, 8'h04), ex(3'd0, 0, 0, 0, 0, 1, 1, 8'h00));
        push(stm(0, 0, 1, 0, 8'h00, 8'h00), ex(3'd0, 0, 0, 0, 0, 0, 1, 8'h00));
`else
        for (int i = 0; i < 20; i++)
            push(stm(0, 0, 1, 0, 8'h00, 8'h04), ex(3'd5, 1, 1, 1, 0, 0, 0, 8'h04));
        push(stm(0, 0, 0, 0, 8'h00, 8'h04), ex(3'd3, 1, 1, 0, 0, 0, 0, 8'h00));
`endif
        for (int idx = 0; q_sb.size() > 0; idx++) begin
            row_t r = q_sb.pop_front();
            drive(r.s);
            tick();
            act = observe();
            checks++;
            if (act !== r.e) begin
                errors++;
                $display("FAIL wake_hold row %0d: got %h expected %h", idx, act, r.e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_flush();
        test_sleep_wake();
        test_masked();
        test_shutdown();
        test_back_to_back();
        test_async_reset();
        test_wake_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
